// File: rtl/mont_sequencer_if.sv
// Handshake and operand bus between the Montgomery sequencer and its environment (top-level plus adder).
// The master modport is the environment side, and the slave modport is the sequencer side.
interface mont_sequencer_if #(
    parameter int NBITS = 512
);
    logic               start;
    logic [NBITS-1:0]   in_a;
    logic [NBITS-1:0]   in_b;
    logic [NBITS-1:0]   in_m;
    logic               add_czero;
    logic               add_sub_done;
    logic               add_clear;
    logic [NBITS+1:0]   add_operand;
    logic               add_enable;
    logic               add_shift;
    logic [3:0]         add_slice;
    logic               add_subtract;
    logic               busy;
    logic               done;
    logic               sub_err;

    modport master (
        output start, in_a, in_b, in_m, add_czero, add_sub_done,
        input  add_clear, add_operand, add_enable, add_shift, add_slice,
               add_subtract, busy, done, sub_err
    );

    modport slave (
        input  start, in_a, in_b, in_m, add_czero, add_sub_done,
        output add_clear, add_operand, add_enable, add_shift, add_slice,
               add_subtract, busy, done, sub_err
    );
endinterface

// File: rtl/mont_sequencer.sv
// This module sequences the 514-bit carry-save Montgomery adder: a 512-bit bit-serial loop, then the carry resolve, then the subtract passes.
// Latency is 1036 to 1051 cycles from start to done. There is no backpressure: start is only taken in IDLE, and start while busy is dropped.
module mont_sequencer #(
    parameter int NBITS   = 512,
    parameter int NSLICE  = 5,
    parameter int MAX_SUB = 4
) (
    input  logic            clk,
    input  logic            rst,
    mont_sequencer_if.slave bus
);
    localparam int          IW        = $clog2(NBITS);
    localparam logic [IW-1:0] LAST_BIT  = IW'(NBITS - 1);
    localparam logic [3:0]  LAST_SLICE = 4'(NSLICE - 1);
    localparam logic [2:0]  LAST_PASS  = 3'(MAX_SUB - 1);
    localparam logic [3:0]  SLICE_IDLE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ADD_A, S_ADD_M, S_RESOLVE, S_SUB, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic [2:0]         pass_q, pass_d;
    logic [3:0]         slice_q, slice_d;
    logic [NBITS-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, neg_m_q, neg_m_d;
    logic               clear_q, clear_d;
    logic               enable_q, enable_d;
    logic               shift_q, shift_d;
    logic               subtract_q, subtract_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sub_err_q, sub_err_d;
    logic [NBITS+1:0]   operand_q, operand_d;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        pass_d    = pass_q;
        slice_d   = SLICE_IDLE;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        neg_m_d   = neg_m_q;
        sub_err_d = sub_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d       = bus.in_a;
                    b_d       = bus.in_b;
                    m_d       = bus.in_m;
                    neg_m_d   = ~bus.in_m + {{(NBITS-1){1'b0}}, 1'b1};
                    sub_err_d = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                i_d     = '0;
                state_d = S_ADD_A;
            end
            S_ADD_A: state_d = S_ADD_M;
            S_ADD_M: begin
                // Bit 0 of B always holds the multiplier bit for the next ADD_A.
                b_d = b_q >> 1;
                if (i_q == LAST_BIT) begin
                    slice_d = 4'd0;
                    state_d = S_RESOLVE;
                end else begin
                    i_d     = i_q + {{(IW-1){1'b0}}, 1'b1};
                    state_d = S_ADD_A;
                end
            end
            S_RESOLVE: begin
                if (slice_q == LAST_SLICE) begin
                    slice_d = 4'd0;
                    pass_d  = 3'd0;
                    state_d = S_SUB;
                end else begin
                    slice_d = slice_q + 4'd1;
                end
            end
            S_SUB: begin
                if (slice_q != LAST_SLICE) begin
                    slice_d = slice_q + 4'd1;
                end else if (bus.add_sub_done) begin
                    state_d = S_DONE;
                end else if (pass_q == LAST_PASS) begin
                    sub_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    pass_d  = pass_q + 3'd1;
                    slice_d = 4'd0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so that each strobe lines up with its state.
        clear_d    = (state_d == S_CLEAR);
        enable_d   = (state_d == S_ADD_A);
        shift_d    = (state_d == S_ADD_M);
        subtract_d = (state_d == S_SUB);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        operand_d  = '0;
        if (state_d == S_ADD_A && b_d[0])
            operand_d = {2'b00, a_d};
        else if (state_d == S_SUB)
            operand_d = {2'b00, neg_m_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            pass_q     <= 3'd0;
            slice_q    <= SLICE_IDLE;
            clear_q    <= 1'b0;
            enable_q   <= 1'b0;
            shift_q    <= 1'b0;
            subtract_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sub_err_q  <= 1'b0;
            operand_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            pass_q     <= pass_d;
            slice_q    <= slice_d;
            clear_q    <= clear_d;
            enable_q   <= enable_d;
            shift_q    <= shift_d;
            subtract_q <= subtract_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sub_err_q  <= sub_err_d;
            operand_q  <= operand_d;
        end
    end

    // The operand registers are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        m_q     <= m_d;
        neg_m_q <= neg_m_d;
    end

    assign bus.add_clear    = clear_q;
    assign bus.add_enable   = enable_q;
    assign bus.add_shift    = shift_q;
    assign bus.add_subtract = subtract_q;
    assign bus.add_slice    = slice_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sub_err      = sub_err_q;
    // The M-or-0 choice depends on the parity that the preceding ADD_A just produced.
    assign bus.add_operand  = (state_q == S_ADD_M)
                            ? (bus.add_czero ? {2'b00, m_q} : '0)
                            : operand_q;
endmodule

// File: tb/tb_mont_sequencer.sv
// This is the directed bench for mont_sequencer. Standalone runs score every output on every cycle against a spec-built timeline.
// Connected runs close the loop through a behavioural adder and check the Montgomery result.
module tb_mont_sequencer;
    typedef logic [524:0] bun_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mont_sequencer_if ifc ();
    mont_sequencer dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    int nvec = 0;
    int nerr = 0;
    bun_t exp_q[$];

    logic         connected = 1'b0;
    logic         cz_drv = 1'b0;
    logic         sd_drv = 1'b0;
    logic [511:0] m_ref = '0;
    logic [514:0] acc = '0;
    logic [514:0] sub_after;

    // Behavioural adder: a plain integer accumulator that stands in for the carry-save registers.
    assign sub_after = (acc >= {3'b000, m_ref}) ? acc - {3'b000, m_ref} : acc;
    always @(posedge clk) begin
        if (ifc.add_clear)
            acc <= '0;
        else if (ifc.add_enable)
            acc <= acc + {1'b0, ifc.add_operand};
        else if (ifc.add_shift)
            acc <= (acc + {1'b0, ifc.add_operand}) >> 1;
        else if (ifc.add_subtract && ifc.add_slice == 4'd4)
            acc <= sub_after;
    end
    assign ifc.add_czero    = connected ? acc[0] : cz_drv;
    assign ifc.add_sub_done = connected
                            ? (ifc.add_subtract && ifc.add_slice == 4'd4 && sub_after < {3'b000, m_ref})
                            : sd_drv;

    bun_t obs;
    assign obs = {ifc.add_clear, ifc.add_enable, ifc.add_shift, ifc.add_subtract,
                  ifc.add_slice, ifc.busy, ifc.done, ifc.sub_err, ifc.add_operand};

    function automatic bun_t mk(input logic clr, input logic en, input logic sh, input logic sb,
                                input logic [3:0] sl, input logic bz, input logic dn,
                                input logic er, input logic [513:0] op);
        return {clr, en, sh, sb, sl, bz, dn, er, op};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input int cyc, input bun_t got, input bun_t exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Standalone run. czero is held at cz. sub_done pulses in cycle sd_cyc (0 means never). Extra start pulses go at p0/p1/p2.
    task automatic run_sa(input string tag, input logic [511:0] a, input logic [511:0] b,
                          input logic [511:0] m, input logic cz, input int sd_cyc,
                          input int p0, input int p1, input int p2);
        logic [512:0] t;
        logic [511:0] negm;
        int passes;
        logic err;
        int n;
        t      = {1'b1, 512'b0} - {1'b0, m};
        negm   = t[511:0];
        passes = (sd_cyc == 0) ? 4 : (sd_cyc - 1035) / 5 + 1;
        err    = (sd_cyc == 0);
        connected = 1'b0;
        cz_drv    = cz;
        exp_q.push_back(mk(1, 0, 0, 0, 4'hF, 1, 0, 0, '0));
        for (int j = 0; j < 512; j++) begin
            exp_q.push_back(mk(0, 1, 0, 0, 4'hF, 1, 0, 0, b[j] ? {2'b00, a} : 514'd0));
            exp_q.push_back(mk(0, 0, 1, 0, 4'hF, 1, 0, 0, cz ? {2'b00, m} : 514'd0));
        end
        for (int s = 0; s < 5; s++)
            exp_q.push_back(mk(0, 0, 0, 0, 4'(s), 1, 0, 0, '0));
        for (int k = 0; k < passes; k++)
            for (int s = 0; s < 5; s++)
                exp_q.push_back(mk(0, 0, 0, 1, 4'(s), 1, 0, 0, {2'b00, negm}));
        exp_q.push_back(mk(0, 0, 0, 0, 4'hF, 0, 1, err, '0));
        exp_q.push_back(mk(0, 0, 0, 0, 4'hF, 0, 0, err, '0));
        n = exp_q.size();

        @(negedge clk);
        ifc.in_a  = a;
        ifc.in_b  = b;
        ifc.in_m  = m;
        ifc.start = 1'b1;
        sd_drv    = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk(tag, c, obs, exp_q.pop_front());
            if (c == 1) begin
                ifc.in_a = rnd512();
                ifc.in_b = rnd512();
                ifc.in_m = rnd512();
            end
            ifc.start = (c == p0) || (c == p1) || (c == p2);
            sd_drv    = (c == sd_cyc);
        end
        ifc.start = 1'b0;
        sd_drv    = 1'b0;
    endtask

    // Connected run. The adder result must equal exp_res, and with a single pass done must land in cycle 1036.
    task automatic run_conn(input string tag, input logic [511:0] a, input logic [511:0] b,
                            input logic [511:0] m, input logic [513:0] exp_res);
        int c;
        connected = 1'b1;
        m_ref     = m;
        @(negedge clk);
        ifc.in_a  = a;
        ifc.in_b  = b;
        ifc.in_m  = m;
        ifc.start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            ifc.start = 1'b0;
            if (c == 1)
                chk({tag, "_clear"}, c, bun_t'(ifc.add_clear), bun_t'(1'b1));
        end while (!ifc.done && c < 1200);
        chk({tag, "_latency"}, c, bun_t'(c), bun_t'(1036));
        chk({tag, "_result"}, c, bun_t'(acc[513:0]), bun_t'(exp_res));
        chk({tag, "_suberr"}, c, bun_t'(ifc.sub_err), bun_t'(1'b0));
        connected = 1'b0;
    endtask

    initial begin
        logic [511:0] ma, mb, mm;
        ifc.start = 1'b0;
        ifc.in_a  = '0;
        ifc.in_b  = '0;
        ifc.in_m  = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_init", 0, obs, mk(0, 0, 0, 0, 4'hF, 0, 0, 0, '0));

        // B=0 with czero held high. Start pulses at 10, 500 and in the done cycle must all be dropped.
        ma = rnd512();
        mm = rnd512();
        mm[0] = 1'b1;
        mm[511] = 1'b1;
        run_sa("b0_czero1", ma, '0, mm, 1'b1, 1035, 10, 500, 1036);

        // The sub_done line is never asserted, so four passes run out and raise sub_err.
        ma = rnd512();
        mb = rnd512();
        mm = rnd512();
        mm[0] = 1'b1;
        run_sa("no_subdone", ma, mb, mm, 1'b0, 0, 0, 0, 0);

        // The next start clears sub_err, and sub_done on the third pass ends the run.
        ma = rnd512();
        mb = rnd512();
        mm = rnd512();
        mm[0] = 1'b1;
        run_sa("third_pass", ma, mb, mm, 1'b1, 1045, 0, 0, 0);

        // Reset mid-operation.
        @(negedge clk);
        ifc.in_b  = rnd512();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_mid", 0, obs, mk(0, 0, 0, 0, 4'hF, 0, 0, 0, '0));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_idle", 0, obs, mk(0, 0, 0, 0, 4'hF, 0, 0, 0, '0));

        run_conn("m13", 512'd5, 512'd7, 512'd13, 514'd1);
        ma = '0;
        ma[510] = 1'b1;
        mm = '0;
        mm[511] = 1'b1;
        mm[0] = 1'b1;
        run_conn("m2p511", ma, ma, mm, 514'd1 << 508);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mont_sequencer.md
# mont_sequencer

Control and operand-sequencing stage that sits directly upstream of the 514-bit carry-save Montgomery adder. It latches A, B and modulus M, then drives the adder through 512 bit-serial Montgomery iterations (add A, then add M or 0 on parity, with shift). After the loop it sequences the 5-slice carry resolve and the repeated slice-wise subtraction of M until the adder reports completion. It owns all adder control strobes and the adder operand bus, and signals completion to the top-level.

## Interface
- NBITS, 512, operand width; fixed for this design.
- NSLICE, 5, resolve/subtract slices per pass (indices 0..4).
- MAX_SUB, 4, maximum subtract passes before error.
- clk  in  1  sole clock, rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- in_a  in  512  multiplicand A (< M).
- in_b  in  512  multiplier B (< M).
- in_m  in  512  modulus M, odd.
- add_czero  in  1  adder sum/carry LSB parity, combinational from adder registers.
- add_sub_done  in  1  adder subtract-finished flag, meaningful only on slice 4 of a subtract pass.
- add_clear  out  1  one-cycle clear to adder registers.
- add_operand  out  514  adder operand input.
- add_enable  out  1  adder capture strobe.
- add_shift  out  1  adder add-and-shift strobe.
- add_slice  out  4  adder slice index; 4'hF when not resolving/subtracting.
- add_subtract  out  1  adder subtract mode.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- sub_err  out  1  set with done if MAX_SUB passes elapse without add_sub_done; cleared on next accepted start.

## Operation
- States: IDLE, CLEAR, ADD_A, ADD_M, RESOLVE, SUB, DONE.
- IDLE: all strobes low, add_slice=4'hF, add_operand=0. start=1 → latch A, B, M and NEG_M = 2^512 − M (512-bit two's complement); busy=1; go CLEAR.
- CLEAR: add_clear=1 for one cycle; bit counter i=0; go ADD_A.
- ADD_A: add_enable=1, add_operand = B[i] ? {2'b0,A} : 0; go ADD_M.
- ADD_M: add_shift=1, add_operand = add_czero ? {2'b0,M} : 0. add_czero is sampled in this same cycle and reflects the registers updated by ADD_A. B shifts right one bit. If i==511, go RESOLVE with slice=0; else i=i+1 and go ADD_A.
- RESOLVE: add_subtract=0, add_operand=0, add_slice steps 0,1,2,3,4 on consecutive cycles; after slice 4, go SUB with slice=0 and pass=0.
- SUB: add_subtract=1, add_operand={2'b0,NEG_M}, add_slice steps 0..4.
  - On slice 4 with add_sub_done=1: go DONE.
  - On slice 4 without add_sub_done: pass=pass+1. If pass reaches MAX_SUB, set sub_err and go DONE; otherwise restart at slice 0.
- DONE: done=1 for one cycle; busy=0; go IDLE. Result is read from the adder, not from this block.
- Arithmetic widths: i is 9-bit and never wraps in use, because the exit is taken at 511. pass is 3-bit. slice is 4-bit.

## Timing
- Reset values: busy=0, done=0, sub_err=0, add_clear=0, add_enable=0, add_shift=0, add_subtract=0, add_slice=4'hF, add_operand=0. State is IDLE.
- All outputs are registered except add_operand in ADD_M, which is muxed from add_czero in the same cycle.
- The start-accept edge is cycle 0. CLEAR is cycle 1. The loop occupies cycles 2..1025. RESOLVE occupies cycles 1026..1030. SUB pass k occupies cycles 1031+5k .. 1035+5k. done is asserted one cycle after the terminating slice 4.
- Minimum latency from start to done is 1036 cycles (one pass). Maximum is 1051 cycles.
- start while busy is ignored; no queuing.
- start and done in the same cycle: start is ignored because the state is not IDLE.
- rst mid-operation: the next cycle shows the reset values. The latched operands are don't-care. The next start runs a full CLEAR.
- in_a, in_b and in_m may change freely after the start-accept cycle.

## Test plan
- Reset: assert rst for 2 cycles mid-stream → every output equals its reset value on the following cycle; add_slice=4'hF.
- Standalone, B=0, bench holds add_czero=1 → all 512 ADD_A operands are 0 and all 512 ADD_M operands equal M; add_enable and add_shift alternate with no gaps over 1024 cycles.
- Connected to adder: M=13, A=5, B=7 → done asserts and the adder result equals 1 (5·7·2^-512 mod 13). Also M=2^511+1, A=B=2^510 → result matches the reference model.
- Standalone, add_sub_done=1 at the first SUB slice 4 → done asserts at cycle 1036 and sub_err=0; add_operand during SUB equals 2^512−M.
- Standalone, add_sub_done held 0 → exactly 4 SUB passes (20 slice cycles), then done with sub_err=1; sub_err clears on the next start.
- start pulses at cycles 10, 500 and 1036 after the first start → the first operation is unaffected; the cycle-1036 start is ignored (state not IDLE); a start in IDLE afterwards is accepted.
